// File: rtl/sonar_multi_sensor.sv
// Multi-channel HC-SR04 range engine: triggers the selected sensor, times its echo, outputs BCD cm.
// Optional macro SONAR_ROUND_EN: round-half-up of the leftover echo ticks (default: truncate).
module sonar_multi_sensor #(
   parameter int unsigned N_CH           = 2,
   parameter int unsigned DIGITOS        = 3,
   parameter int unsigned CICLOS_POR_CM  = 2941,
   parameter int unsigned TRIGGER_CICLOS = 500,
   parameter int unsigned TIMEOUT_CICLOS = 1500000
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     medir,
   input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] canal,
   input  logic [N_CH-1:0]                          echo,
   output logic [N_CH-1:0]                          trigger,
   output logic [4*DIGITOS-1:0]                     medida,
   output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] canal_out,
   output logic                                     pronto,
   output logic                                     erro,
   output logic [3:0]                               db_estado
);

   localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned BW     = 4 * DIGITOS;
   localparam int unsigned TW     = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;
   localparam int unsigned CntMax = (TIMEOUT_CICLOS > TRIGGER_CICLOS) ? TIMEOUT_CICLOS
                                                                       : TRIGGER_CICLOS;
   localparam int unsigned NW     = $clog2(CntMax + 1);
   localparam logic [BW-1:0] AllNines = {DIGITOS{4'h9}};

   typedef enum logic [3:0] {
      StInicial    = 4'd0,
      StPrepara    = 4'd1,
      StTrigger    = 4'd2,
      StEsperaEcho = 4'd3,
      StMede       = 4'd4,
      StArmazena   = 4'd5,
      StFinal      = 4'd6,
      StErro       = 4'd7
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   canal_q, canal_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [BW-1:0]   medida_q, medida_d;
   logic [CW-1:0]   canal_out_q, canal_out_d;
   logic            erro_q, erro_d;
   logic [N_CH-1:0] trigger_q, trigger_d;
   logic            sync1_q, sync2_q, prev_q;
   logic            echo_sel;
   logic            echo_rise;
   logic            count_step;
   logic            round_up;

   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      if (v == AllNines) begin
         return v;
      end
      for (int i = 0; i < int'(DIGITOS); i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      echo_sel = 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (canal_q == CW'(i)) begin
            echo_sel = echo[i];
         end
      end
   end

   // prev_q lets ESPERA_ECHO demand a fresh rising edge even if echo is already high.
   assign echo_rise = sync2_q & ~prev_q;

   always_comb begin
`ifdef SONAR_ROUND_EN
      round_up = (32'(tick_q) >= (CICLOS_POR_CM / 2));
`else
      round_up = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      canal_d     = canal_q;
      cnt_d       = cnt_q;
      tick_d      = tick_q;
      bcd_d       = bcd_q;
      medida_d    = medida_q;
      canal_out_d = canal_out_q;
      erro_d      = erro_q;
      trigger_d   = '0;
      count_step  = 1'b0;

      unique case (state_q)
         StInicial: begin
            if (medir) state_d = StPrepara;
         end
         StPrepara: begin
            canal_d = (32'(canal) >= N_CH) ? CW'(N_CH - 1) : canal;
            cnt_d   = '0;
            tick_d  = '0;
            bcd_d   = '0;
            state_d = StTrigger;
         end
         StTrigger: begin
            if (cnt_q == NW'(TRIGGER_CICLOS - 1)) begin
               cnt_d   = '0;
               state_d = StEsperaEcho;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StEsperaEcho: begin
            if (echo_rise) begin
               // The detecting cycle is the first echo-high cycle, so it is counted too.
               cnt_d      = '0;
               count_step = 1'b1;
               state_d    = StMede;
            end else if (cnt_q == NW'(TIMEOUT_CICLOS - 1)) begin
               state_d = StErro;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StMede: begin
            if (!sync2_q) begin
               state_d = StArmazena;
            end else if (cnt_q == NW'(TIMEOUT_CICLOS - 1)) begin
               state_d = StErro;
            end else begin
               cnt_d      = cnt_q + 1'b1;
               count_step = 1'b1;
            end
         end
         StArmazena: begin
            medida_d    = round_up ? bcd_inc(bcd_q) : bcd_q;
            canal_out_d = canal_q;
            erro_d      = 1'b0;
            state_d     = StFinal;
         end
         StFinal: state_d = StInicial;
         StErro:  state_d = StInicial;
         default: state_d = StInicial;
      endcase

      // Error result is loaded on entry so it is valid while pronto is high.
      if (state_d == StErro && state_q != StErro) begin
         medida_d    = '1;
         canal_out_d = canal_q;
         erro_d      = 1'b1;
      end

      if (count_step) begin
         if (tick_q == TW'(CICLOS_POR_CM - 1)) begin
            tick_d = '0;
            bcd_d  = bcd_inc(bcd_q);
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end

      if (state_d == StTrigger) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            trigger_d[i] = (canal_d == CW'(i));
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StInicial;
         canal_q     <= '0;
         cnt_q       <= '0;
         tick_q      <= '0;
         bcd_q       <= '0;
         medida_q    <= '0;
         canal_out_q <= '0;
         erro_q      <= 1'b0;
         trigger_q   <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         canal_q     <= canal_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         bcd_q       <= bcd_d;
         medida_q    <= medida_d;
         canal_out_q <= canal_out_d;
         erro_q      <= erro_d;
         trigger_q   <= trigger_d;
         sync1_q     <= echo_sel;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
      end
   end

   assign trigger   = trigger_q;
   assign medida    = medida_q;
   assign canal_out = canal_out_q;
   assign erro      = erro_q;
   assign pronto    = (state_q == StFinal) || (state_q == StErro);
   assign db_estado = state_q;

endmodule

// File: tb/tb_sonar_multi_sensor.sv
// Scoreboard bench for sonar_multi_sensor with scaled timing (10 cycles/cm, 12000-cycle timeout).
module tb_sonar_multi_sensor;

   localparam int unsigned NCh  = 3;
   localparam int unsigned Cpc  = 10;
   localparam int unsigned Trig = 5;
   localparam int unsigned Tmo  = 12000;
`ifdef SONAR_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        medir;
   logic [1:0]  canal;
   logic [2:0]  echo;
   logic [2:0]  trigger;
   logic [11:0] medida;
   logic [1:0]  canal_out;
   logic        pronto;
   logic        erro;
   logic [3:0]  db_estado;

   typedef struct packed {
      logic [11:0] medida;
      logic [1:0]  ch;
      logic        erro;
      logic [3:0]  st;
   } exp_t;

   exp_t exp_q[$];
   int   trig_q[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   n_pronto  = 0;
   int   n_issued  = 0;
   int   tw        = 0;
   logic [2:0] tpat = '0;

   sonar_multi_sensor #(
      .N_CH          (NCh),
      .DIGITOS       (3),
      .CICLOS_POR_CM (Cpc),
      .TRIGGER_CICLOS(Trig),
      .TIMEOUT_CICLOS(Tmo)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .medir    (medir),
      .canal    (canal),
      .echo     (echo),
      .trigger  (trigger),
      .medida   (medida),
      .canal_out(canal_out),
      .pronto   (pronto),
      .erro     (erro),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // Monitor: result scoreboard and trigger pulse checker.
   always @(negedge clock) begin
      exp_t e;
      int   ch;
      if (reset && pronto) begin
         n_pronto++;
         if (exp_q.size() == 0) begin
            check("unexpected_pronto", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("medida", 32'(medida), 32'(e.medida));
            check("canal_out", 32'(canal_out), 32'(e.ch));
            check("erro", 32'(erro), 32'(e.erro));
            check("estado_at_pronto", 32'(db_estado), 32'(e.st));
         end
      end
      if (trigger != 3'b000) begin
         if (tw == 0) tpat = trigger;
         else if (trigger != tpat) check("trigger_stable", 32'(trigger), 32'(tpat));
         tw++;
      end else if (tw > 0) begin
         if (trig_q.size() == 0) begin
            check("unexpected_trigger", 32'd1, 32'd0);
         end else begin
            ch = trig_q.pop_front();
            check("trigger_chan", 32'(tpat), 32'd1 << ch);
            check("trigger_width", 32'(tw), 32'(Trig));
         end
         tw = 0;
      end
   end

   task automatic wait_state(input logic [3:0] st, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         if (db_estado == st) return;
      end
      check("wait_state", 32'(db_estado), 32'(st));
   endtask

   task automatic wait_pronto(input int target, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (n_pronto >= target) return;
         @(posedge clock);
      end
      check("pronto_timeout", 32'(n_pronto), 32'(target));
   endtask

   // h == 0 means the sensor never answers.
   task automatic run(input int ch_req, input int ch_eff, input int h,
                      input logic [11:0] exp_med, input logic exp_err, input bit tog);
      exp_t e;
      int   target;
      int   other;
      e.medida = exp_med;
      e.ch     = 2'(ch_eff);
      e.erro   = exp_err;
      e.st     = exp_err ? 4'd7 : 4'd6;
      exp_q.push_back(e);
      trig_q.push_back(ch_eff);
      n_issued++;
      target = n_issued;
      other  = (ch_eff == 0) ? 1 : 0;
      @(posedge clock);
      #1 canal = 2'(ch_req);
      medir = 1'b1;
      repeat (5) @(posedge clock);
      #1 medir = 1'b0;
      wait_state(4'd3, 100);
      if (h > 0) begin
         repeat (3) @(posedge clock);
         #1 echo[ch_eff] = 1'b1;
         for (int i = 0; i < h; i++) begin
            @(posedge clock);
            #1;
            if (tog) echo[other] = ~echo[other];
         end
         echo[ch_eff] = 1'b0;
         echo[other]  = 1'b0;
         if (!exp_err) begin
            for (int k = 1; k <= 4; k++) begin
               @(posedge clock);
               @(negedge clock);
               check("latency_pronto", 32'(pronto), (k == 4) ? 32'd1 : 32'd0);
            end
         end
      end
      wait_pronto(target, Tmo + 200);
      repeat (2) @(posedge clock);
   endtask

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      medir = 1'b0;
      canal = 2'd0;
      echo  = 3'b000;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_estado", 32'(db_estado), 32'd0);
      check("rst_trigger", 32'(trigger), 32'd0);
      check("rst_medida", 32'(medida), 32'd0);
      check("rst_canal_out", 32'(canal_out), 32'd0);
      check("rst_pronto", 32'(pronto), 32'd0);
      check("rst_erro", 32'(erro), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;

      // 1000 cycles = 100 cm; 748 = 74.8; 1005 = 100.5 (half-up boundary); 505 = 50.5
      run(0, 0, 1000, 12'h100, 1'b0, 1'b0);
      run(1, 1, 748, RoundEn ? 12'h075 : 12'h074, 1'b0, 1'b0);
      run(0, 0, 1700, 12'h170, 1'b0, 1'b1);
      run(0, 0, 1005, RoundEn ? 12'h101 : 12'h100, 1'b0, 1'b0);
      run(3, 2, 505, RoundEn ? 12'h051 : 12'h050, 1'b0, 1'b0);
      run(0, 0, 11000, 12'h999, 1'b0, 1'b0);
      run(1, 1, 0, 12'hFFF, 1'b1, 1'b0);
      run(0, 0, 14000, 12'hFFF, 1'b1, 1'b0);
      run(0, 0, 1000, 12'h100, 1'b0, 1'b0);

      // Abort mid-MEDE with a one-cycle reset: no result may follow.
      trig_q.push_back(0);
      @(posedge clock);
      #1 canal = 2'd0;
      medir = 1'b1;
      @(posedge clock);
      #1 medir = 1'b0;
      wait_state(4'd3, 100);
      @(posedge clock);
      #1 echo[0] = 1'b1;
      repeat (50) @(posedge clock);
      @(negedge clock);
      check("mid_mede_estado", 32'(db_estado), 32'd4);
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("abort_estado", 32'(db_estado), 32'd0);
      check("abort_trigger", 32'(trigger), 32'd0);
      check("abort_pronto", 32'(pronto), 32'd0);
      check("abort_medida", 32'(medida), 32'd0);
      repeat (100) @(posedge clock);
      #1 echo[0] = 1'b0;
      repeat (50) @(posedge clock);
      check("abort_no_pronto", 32'(n_pronto), 32'(n_issued));

      run(1, 1, 200, 12'h020, 1'b0, 1'b0);

      repeat (5) @(posedge clock);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("trigger_queue_empty", 32'(trig_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
